// File: rtl/line_pkg.sv
// Shared definitions for the line raster engine: FSM state encoding
// and default coordinate / screen / frame-buffer geometry.
package line_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        STEP  = 2'd2,
        DONE  = 2'd3
    } line_state_t;

    localparam int DEF_WIDTH    = 13;
    localparam int DEF_SCREEN_W = 640;
    localparam int DEF_SCREEN_H = 480;
    localparam int DEF_ADDR_W   = 19;
    localparam int DEF_COLOR_W  = 3;

endpackage

// File: rtl/line_clip_addr.sv
// Combinational screen clip and linear frame-buffer address.
// Ports: x, y (signed point) -> in_bounds, addr = y*SCREEN_W + x.
module line_clip_addr
    import line_pkg::*;
#(
    parameter int CW       = DEF_WIDTH + 2,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic signed [CW-1:0]  x,
    input  logic signed [CW-1:0]  y,
    output logic                  in_bounds,
    output logic [ADDR_W-1:0]     addr
);

    localparam logic signed [CW-1:0] W_LIM = CW'(SCREEN_W);
    localparam logic signed [CW-1:0] H_LIM = CW'(SCREEN_H);

    logic [ADDR_W-1:0] xu;
    logic [ADDR_W-1:0] yu;

    assign in_bounds = !x[CW-1] && (x < W_LIM)
                    && !y[CW-1] && (y < H_LIM);

    // Address is only meaningful when in_bounds; wraps to ADDR_W bits.
    assign xu   = ADDR_W'($unsigned(x));
    assign yu   = ADDR_W'($unsigned(y));
    assign addr = yu * ADDR_W'(SCREEN_W) + xu;

endmodule

// File: rtl/line_raster_engine.sv
// Bresenham line rasteriser writing one pixel per cycle to a frame buffer.
// Ports: cmd_valid/cmd_ready + endpoints/colour in; FB_WE/FB_addr/color_out
// with FB_ready back-pressure; busy and a one-cycle sys_finish pulse.
module line_raster_engine
    import line_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int COLOR_W  = DEF_COLOR_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic signed [WIDTH-1:0]   x0,
    input  logic signed [WIDTH-1:0]   y0,
    input  logic signed [WIDTH-1:0]   x1,
    input  logic signed [WIDTH-1:0]   y1,
    input  logic [COLOR_W-1:0]        color_in,
    input  logic                      FB_ready,
    output logic                      FB_WE,
    output logic [ADDR_W-1:0]         FB_addr,
    output logic [COLOR_W-1:0]        color_out,
    output logic                      busy,
    output logic                      sys_finish
);

    localparam int EW = WIDTH + 2;
    localparam logic signed [EW-1:0] ZERO = '0;
    localparam logic signed [EW-1:0] P1   = EW'(1);
    localparam logic signed [EW-1:0] M1   = '1;

    line_state_t state, state_nx;

    logic signed [EW-1:0] x0_r, y0_r, x1_r, y1_r;
    logic signed [EW-1:0] x, y, dx, dy, sx, sy, err;
    logic [COLOR_W-1:0]   col_r;

    logic signed [EW-1:0] ddx, ddy, adx, ady, sx_c, sy_c;
    logic signed [EW:0]   e2, dx_w, dy_w;
    logic                 step_x, step_y, last;
    logic                 in_bounds, adv, take;
    logic [ADDR_W-1:0]    pix_addr;

    assign take = cmd_valid && cmd_ready;

    assign ddx  = x1_r - x0_r;
    assign ddy  = y1_r - y0_r;
    assign adx  = ddx[EW-1] ? -ddx : ddx;
    assign ady  = ddy[EW-1] ? -ddy : ddy;
    assign sx_c = ddx[EW-1] ? M1 : ((ddx == ZERO) ? ZERO : P1);
    assign sy_c = ddy[EW-1] ? M1 : ((ddy == ZERO) ? ZERO : P1);

    // One extra bit so 2*err never wraps.
    assign e2     = {err, 1'b0};
    assign dx_w   = {dx[EW-1], dx};
    assign dy_w   = {dy[EW-1], dy};
    assign step_x = (e2 >= dy_w);
    assign step_y = (e2 <= dx_w);
    assign last   = (x == x1_r) && (y == y1_r);

    // Off-screen points never wait on the frame buffer.
    assign adv = (state == STEP) && (!in_bounds || FB_ready);

    line_clip_addr #(
        .CW       (EW),
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H),
        .ADDR_W   (ADDR_W)
    ) u_clip (
        .x         (x),
        .y         (y),
        .in_bounds (in_bounds),
        .addr      (pix_addr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (take) state_nx = SETUP;
            SETUP: state_nx = STEP;
            STEP:  if (adv && last) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready  = (state == IDLE) && !reset;
        busy       = (state != IDLE);
        sys_finish = (state == DONE);
        FB_WE      = (state == STEP) && in_bounds;
        FB_addr    = FB_WE ? pix_addr : '0;
        color_out  = FB_WE ? col_r : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x0_r  <= '0;
            y0_r  <= '0;
            x1_r  <= '0;
            y1_r  <= '0;
            col_r <= '0;
            x     <= '0;
            y     <= '0;
            dx    <= '0;
            dy    <= '0;
            sx    <= '0;
            sy    <= '0;
            err   <= '0;
        end else begin
            if (take) begin
                x0_r  <= EW'(x0);
                y0_r  <= EW'(y0);
                x1_r  <= EW'(x1);
                y1_r  <= EW'(y1);
                col_r <= color_in;
            end
            if (state == SETUP) begin
                dx  <= adx;
                dy  <= -ady;
                sx  <= sx_c;
                sy  <= sy_c;
                err <= adx - ady;
                x   <= x0_r;
                y   <= y0_r;
            end
            if (adv && !last) begin
                if (step_x) x <= x + sx;
                if (step_y) y <= y + sy;
                err <= err + (step_x ? dy : ZERO)
                           + (step_y ? dx : ZERO);
            end
        end
    end

endmodule
